demux1to2_stream: RTL and testbench

//  Registered 1-to-NUM_OUT stream demultiplexer; the routing counterpart of mux2to1.

---
 rtl/demux1to2_stream_if.sv | 26 ++
 rtl/demux1to2_stream.sv | 78 +++++++
 tb/tb_demux1to2_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/demux1to2_stream_if.sv
// Valid/ready handshake bundle for demux1to2_stream: one producer side and NUM_OUT consumer lanes.
// slave = the demultiplexer's view; master = the environment driving it.
interface demux1to2_stream_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
);
  localparam int NUM_OUT = 2 ** SEL_W;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux1to2_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer with a single-entry output register.
// Define DEMUX_CNT_EN to add per-channel 16-bit delivered-beat counters on out_cnt.
module demux1to2_stream #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic clk,
  input  logic rst,
  demux1to2_stream_if.slave s_if
`ifdef DEMUX_CNT_EN
  ,
  output logic [(2**SEL_W)*16-1:0] out_cnt
`endif
);
  localparam int NUM_OUT = 2 ** SEL_W;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_data;
  logic [SEL_W-1:0]   r_sel;
  logic               w_deliver;
  logic               w_accept;
  logic               w_in_ready;

  // Only the held beat's own channel can release it; other ready bits are ignored.
  assign w_deliver  = (r_state == S_FULL) && s_if.out_ready[r_sel];
  assign w_in_ready = (r_state == S_EMPTY) || w_deliver;
  assign w_accept   = s_if.in_valid && w_in_ready;

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_data  = r_data;
  assign s_if.out_valid = (r_state == S_FULL) ? (NUM_OUT'(1) << r_sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (w_deliver && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_sel  <= '0;
    end else if (w_accept) begin
      r_data <= s_if.in_data;
      r_sel  <= s_if.in_sel;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [15:0] r_cnt [NUM_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) r_cnt[k] <= '0;
    end else if (w_deliver) begin
      r_cnt[r_sel] <= r_cnt[r_sel] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    assign out_cnt[16*g +: 16] = r_cnt[g];
  end
`endif
endmodule

// File: tb/tb_demux1to2_stream.sv
// Bench for demux1to2_stream: directed scenarios plus random traffic against a queue-based model.
module tb_demux1to2_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1to2_stream_if #(.DATA_W(8), .SEL_W(1)) bus ();

`ifdef DEMUX_CNT_EN
  logic [31:0] out_cnt;
  demux1to2_stream #(.DATA_W(8), .SEL_W(1)) dut (.clk(clk), .rst(rst), .s_if(bus), .out_cnt(out_cnt));
`else
  demux1to2_stream #(.DATA_W(8), .SEL_W(1)) dut (.clk(clk), .rst(rst), .s_if(bus));
`endif

  typedef struct { logic [7:0] d; logic s; } beat_t;
  beat_t      q[$];
  logic [7:0] m_data;
  int         cnt_m [2];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
  task automatic step(input bit vld, input logic [7:0] d, input logic s, input logic [1:0] ordy);
    bit         e_rdy;
    logic [1:0] e_vld;
    bus.in_valid  = vld;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.out_ready = ordy;
    #1;
    e_rdy = (q.size() == 0) || (ordy[q[0].s] == 1'b1);
    e_vld = (q.size() == 0) ? 2'b00 : (q[0].s ? 2'b10 : 2'b01);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_rdy});
    chk("out_valid", {30'd0, bus.out_valid}, {30'd0, e_vld});
    chk("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
`ifdef DEMUX_CNT_EN
    chk("cnt0", {16'd0, out_cnt[15:0]}, cnt_m[0]);
    chk("cnt1", {16'd0, out_cnt[31:16]}, cnt_m[1]);
`endif
    @(posedge clk);
    if (q.size() > 0 && ordy[q[0].s]) begin
      cnt_m[q[0].s] = (cnt_m[q[0].s] + 1) % 65536;
      void'(q.pop_front());
    end
    if (vld && e_rdy) begin
      q.push_back('{d: d, s: s});
      m_data = d;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    q.delete();
    m_data   = 8'h00;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sel    = 1'b0;
    bus.out_ready = 2'b00;
    m_data   = 8'h00;
    cnt_m[0] = 0;
    cnt_m[1] = 0;

    // Reset state
    do_reset(2);
    step(1'b0, 8'h00, 1'b0, 2'b00);

    // Route to ch0, then ch1
    step(1'b1, 8'hA5, 1'b0, 2'b11);
    step(1'b1, 8'h3C, 1'b1, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b11);

    // Backpressure on ch1 while ch0 is ready; in_sel wiggles must be ignored
    step(1'b1, 8'h5E, 1'b1, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'(i), 2'b01);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b10);

    // Streaming alternate channels, data 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'((i - 1) % 2), 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    chk("stream_drained", q.size(), 0);

    // Reset while holding a beat
    step(1'b1, 8'hC3, 1'b0, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    do_reset(1);
    step(1'b0, 8'h00, 1'b0, 2'b11);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

`ifdef DEMUX_CNT_EN
    // Counter wrap on ch0 with ch1 holding a nonzero count
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1, 2'b11);
    for (int i = 0; i < 65536; i++) step(1'b1, 8'($urandom), 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    chk("wrap_cnt0", {16'd0, out_cnt[15:0]}, 32'd0);
    chk("wrap_cnt1", {16'd0, out_cnt[31:16]}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
